w_stage_grf: RTL and testbench
==============================

# w_stage_grf

Write-back stage plus general register file for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs (`W_PC`, `W_IR`, `W_DMRD`, `W_ALUO`) and decodes the W-stage instruction into write enable, destination and write data. It holds the 32×32 register file, serves the two D-stage read ports with same-cycle write-through bypass, and exports the W-stage write triple for the hazard/forwarding unit.

## Interface
- `ENABLE_TRACE`, default 1: when 1, emit one `$display` line per committed register write (simulation only; no effect on synthesis).
- `clk` input 1: clock; all register-file writes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `W_PC` input 32: PC of the W-stage instruction.
- `W_IR` input 32: W-stage instruction word (0 = nop).
- `W_DMRD` input 32: data-memory read data latched in MEM/WB.
- `W_ALUO` input 32: ALU result latched in MEM/WB.
- `D_rs_addr` input 5: D-stage read address A.
- `D_rt_addr` input 5: D-stage read address B.
- `D_rs_data` output 32: read data A (combinational).
- `D_rt_data` output 32: read data B (combinational).
- `W_we` output 1: effective write enable (0 when destination is $0).
- `W_waddr` output 5: decoded destination register (0 when no write).
- `W_wdata` output 32: decoded write data (0 when no write).

## Operation
- Decode from `W_IR[31:26]` (op), `W_IR[5:0]` (funct):
  - op 000000, funct 100001 (addu) / 100011 (subu): dest = `W_IR[15:11]`, data = `W_ALUO`.
  - op 001101 (ori), 001111 (lui): dest = `W_IR[20:16]`, data = `W_ALUO`.
  - op 100011 (lw): dest = `W_IR[20:16]`, data = `W_DMRD`.
  - op 000011 (jal): dest = 31, data = `W_PC + 8` (32-bit wrap).
  - All others (sw, beq, jr, nop, undefined): no write; `W_we`=0, `W_waddr`=0, `W_wdata`=0.
- `W_we` = decoded write AND dest ≠ 0. Writes to $0 are dropped; `W_waddr` still shows the decoded dest, `W_wdata` the decoded data.
- Register file: 32 × 32-bit; $0 reads 0 always, never stored.
- Read ports: if addr = 0 → 0; else if `W_we` and addr = `W_waddr` → `W_wdata` (bypass); else stored value. Ports independent; both may hit bypass simultaneously.
- Trace (ENABLE_TRACE=1, `W_we`=1, `rst`=0, at rising edge): `"%d@%h: $%d <= %h"` with `$time`, `W_PC`, `W_waddr`, `W_wdata`.

## Timing
- Reset: on rising edge with `rst`=1, all 32 registers ← 0; write suppressed that cycle, no trace line. Reset overrides any pending write.
- Read outputs are purely combinational; no added latency. `W_we/W_waddr/W_wdata` are combinational from W inputs.
- Write commits at the rising edge ending the cycle in which the instruction is in W; visible via bypass during that cycle, via storage thereafter.
- Reset mid-stream: instruction in W at the reset edge is discarded; MEM/WB also resets to 0 (nop), so the next cycle writes nothing.
- No stall input: every non-reset cycle commits whatever is in W.

## Test plan
- Reset then read all 32 addresses on both ports → all 0; `W_we`=0 with `W_IR`=0.
- ori $5 (`W_IR`=0x34050000|imm, `W_ALUO`=0x1234), `D_rs_addr`=5 same cycle → `D_rs_data`=0x1234 (bypass); next cycle with nop → still 0x1234 from storage.
- lw $8 with `W_DMRD`=0xDEADBEEF, `W_ALUO`=0x10 → $8=0xDEADBEEF; addu $9 with `W_ALUO`=0x7 → $9=7 (rd path, not rt).
- jal at `W_PC`=0x00003000 → $31=0x00003008; jal at `W_PC`=0xFFFFFFFC → $31=0x00000004 (wrap).
- addu with rd=0, `W_ALUO`=0xFFFFFFFF → `W_we`=0, $0 reads 0 via both ports; sw/beq/jr → no register changes, no trace.
- Write $3=0xAA, then assert `rst` in a cycle where W holds ori $3 (`W_ALUO`=0xBB) → after edge $3=0, no trace line; both ports addr 3 → 0.

Source files
------------

// File: rtl/w_stage_grf.sv
// Write-back stage and 32x32 general register file for the five-stage MIPS pipeline.
// Decodes the W-stage instruction into a write triple and serves the two D-stage read ports with write-through bypass.
module w_stage_grf #(
    parameter bit ENABLE_TRACE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_IR,
    input  logic [31:0] W_DMRD,
    input  logic [31:0] W_ALUO,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        W_we,
    output logic [4:0]  W_waddr,
    output logic [31:0] W_wdata
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        dec_write;
    logic [4:0]  dec_dest;
    logic [31:0] dec_data;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // The rs field and shamt never influence the write-back decision.
    logic unused_ir_bits;

    assign op             = W_IR[31:26];
    assign funct          = W_IR[5:0];
    assign unused_ir_bits = ^{W_IR[25:21], W_IR[10:6]};

    always_comb begin
        dec_write = 1'b0;
        dec_dest  = 5'd0;
        dec_data  = 32'd0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    dec_write = 1'b1;
                    dec_dest  = W_IR[15:11];
                    dec_data  = W_ALUO;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_write = 1'b1;
                dec_dest  = W_IR[20:16];
                dec_data  = W_ALUO;
            end
            OP_LW: begin
                dec_write = 1'b1;
                dec_dest  = W_IR[20:16];
                dec_data  = W_DMRD;
            end
            OP_JAL: begin
                dec_write = 1'b1;
                dec_dest  = 5'd31;
                dec_data  = W_PC + 32'd8;
            end
            default: begin
                dec_write = 1'b0;
            end
        endcase
    end

    // $0 is hardwired: a decoded write to it is reported but never committed.
    assign W_we    = dec_write && (dec_dest != 5'd0);
    assign W_waddr = dec_dest;
    assign W_wdata = dec_data;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'd0;
            end
        end else if (W_we) begin
            regs_d[W_waddr] = W_wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        if (D_rs_addr == 5'd0) begin
            D_rs_data = 32'd0;
        end else if (W_we && D_rs_addr == W_waddr) begin
            D_rs_data = W_wdata;
        end else begin
            D_rs_data = regs_q[D_rs_addr];
        end
    end

    always_comb begin
        if (D_rt_addr == 5'd0) begin
            D_rt_data = 32'd0;
        end else if (W_we && D_rt_addr == W_waddr) begin
            D_rt_data = W_wdata;
        end else begin
            D_rt_data = regs_q[D_rt_addr];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (ENABLE_TRACE && W_we && !rst) begin
            $display("%d@%h: $%d <= %h", $time, W_PC, W_waddr, W_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_w_stage_grf.sv
// Scoreboard bench for w_stage_grf: directed vectors push expected read/write outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_w_stage_grf;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] W_PC;
    logic [31:0] W_IR;
    logic [31:0] W_DMRD;
    logic [31:0] W_ALUO;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        W_we;
    logic [4:0]  W_waddr;
    logic [31:0] W_wdata;

    exp_t  exp_q  [$];
    string name_q [$];
    int    num_vectors;
    int    num_miscompares;

    w_stage_grf #(.ENABLE_TRACE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .W_PC      (W_PC),
        .W_IR      (W_IR),
        .W_DMRD    (W_DMRD),
        .W_ALUO    (W_ALUO),
        .D_rs_addr (D_rs_addr),
        .D_rt_addr (D_rt_addr),
        .D_rs_data (D_rs_data),
        .D_rt_data (D_rt_data),
        .W_we      (W_we),
        .W_waddr   (W_waddr),
        .W_wdata   (W_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input string field,
                               input logic [31:0] act, input logic [31:0] exp_val);
        if (act !== exp_val) begin
            num_miscompares++;
            $display("[TB] FAIL %s.%s: got %h expected %h", nm, field, act, exp_val);
        end
    endtask

    // Drives one W-stage cycle, queues what the DUT should show during it, then advances past the edge.
    task automatic applyStimulus(input string nm, input logic r,
                                 input logic [31:0] ir, input logic [31:0] pc,
                                 input logic [31:0] dmrd, input logic [31:0] aluo,
                                 input logic [4:0] rsa, input logic [4:0] rta,
                                 input logic [31:0] ers, input logic [31:0] ert,
                                 input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        exp_t e;
        rst       = r;
        W_IR      = ir;
        W_PC      = pc;
        W_DMRD    = dmrd;
        W_ALUO    = aluo;
        D_rs_addr = rsa;
        D_rt_addr = rta;
        e.rs_data = ers;
        e.rt_data = ert;
        e.we      = ewe;
        e.waddr   = ewa;
        e.wdata   = ewd;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            num_vectors++;
            checkOutput(nm, "rs_data", D_rs_data, e.rs_data);
            checkOutput(nm, "rt_data", D_rt_data, e.rt_data);
            checkOutput(nm, "we", {31'd0, W_we}, {31'd0, e.we});
            checkOutput(nm, "waddr", {27'd0, W_waddr}, {27'd0, e.waddr});
            checkOutput(nm, "wdata", W_wdata, e.wdata);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        num_vectors     = 0;
        num_miscompares = 0;
        rst       = 1'b1;
        W_IR      = 32'd0;
        W_PC      = 32'd0;
        W_DMRD    = 32'd0;
        W_ALUO    = 32'd0;
        D_rs_addr = 5'd0;
        D_rt_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            applyStimulus($sformatf("reset_read_%0d", i), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                          5'(i), 5'(31 - i), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        end

        applyStimulus("ori5_bypass", 1'b0, 32'h34051234, 32'h00001000, 32'h0, 32'h00001234,
                      5'd5, 5'd5, 32'h1234, 32'h1234, 1'b1, 5'd5, 32'h1234);
        applyStimulus("ori5_stored", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd5, 5'd0, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus("lw8", 1'b0, 32'h8C080010, 32'h00001008, 32'hDEADBEEF, 32'h00000010,
                      5'd8, 5'd5, 32'hDEADBEEF, 32'h1234, 1'b1, 5'd8, 32'hDEADBEEF);
        applyStimulus("addu9_rd", 1'b0, 32'h00224821, 32'h0000100C, 32'h0, 32'h00000007,
                      5'd9, 5'd8, 32'h7, 32'hDEADBEEF, 1'b1, 5'd9, 32'h7);
        applyStimulus("addu9_not_rt", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd9, 5'd2, 32'h7, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus("subu10", 1'b0, 32'h00005023, 32'h00001010, 32'h0, 32'h00000055,
                      5'd10, 5'd10, 32'h55, 32'h55, 1'b1, 5'd10, 32'h55);
        applyStimulus("lui11", 1'b0, 32'h3C0BABCD, 32'h00001014, 32'h0, 32'hABCD0000,
                      5'd11, 5'd10, 32'hABCD0000, 32'h55, 1'b1, 5'd11, 32'hABCD0000);
        applyStimulus("jal_3000", 1'b0, 32'h0C000C00, 32'h00003000, 32'h0, 32'h00000099,
                      5'd31, 5'd11, 32'h00003008, 32'hABCD0000, 1'b1, 5'd31, 32'h00003008);
        applyStimulus("jal_wrap", 1'b0, 32'h0C000C00, 32'hFFFFFFFC, 32'h0, 32'h00000099,
                      5'd31, 5'd31, 32'h00000004, 32'h00000004, 1'b1, 5'd31, 32'h00000004);
        applyStimulus("jal_wrap_stored", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd31, 5'd9, 32'h00000004, 32'h7, 1'b0, 5'd0, 32'h0);
        applyStimulus("addu_rd0", 1'b0, 32'h00220021, 32'h00001018, 32'h0, 32'hFFFFFFFF,
                      5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF);
        applyStimulus("sw_nowrite", 1'b0, 32'hAC050004, 32'h0000101C, 32'h00000077, 32'h00000004,
                      5'd5, 5'd8, 32'h1234, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        applyStimulus("beq_nowrite", 1'b0, 32'h10A50003, 32'h00001020, 32'h0, 32'h00000111,
                      5'd9, 5'd10, 32'h7, 32'h55, 1'b0, 5'd0, 32'h0);
        applyStimulus("jr_nowrite", 1'b0, 32'h03E00008, 32'h00001024, 32'h0, 32'h00000222,
                      5'd31, 5'd5, 32'h00000004, 32'h1234, 1'b0, 5'd0, 32'h0);
        applyStimulus("after_nowrite", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd5, 5'd31, 32'h1234, 32'h00000004, 1'b0, 5'd0, 32'h0);
        applyStimulus("ori3_aa", 1'b0, 32'h340300AA, 32'h00001028, 32'h0, 32'h000000AA,
                      5'd3, 5'd9, 32'hAA, 32'h7, 1'b1, 5'd3, 32'hAA);
        applyStimulus("ori3_stored", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd3, 5'd3, 32'hAA, 32'hAA, 1'b0, 5'd0, 32'h0);
        applyStimulus("reset_with_ori3", 1'b1, 32'h340300BB, 32'h0000102C, 32'h0, 32'h000000BB,
                      5'd3, 5'd5, 32'hBB, 32'h1234, 1'b1, 5'd3, 32'hBB);
        applyStimulus("post_reset_r3", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd3, 5'd3, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus("post_reset_others", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                      5'd5, 5'd31, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            num_miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
